// File: rtl/axi4_lite_arbiter.sv
// ============================================================================
// Module      : axi4_lite_arbiter
// Description : Two-master AXI4-Lite arbiter; grants one whole transaction
//               (AW+W+B or AR+R) at a time, round-robin between masters.
//               Optional macro ARB_FIXED_PRIORITY_EN: master 0 always wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module axi4_lite_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // master side, slice 0 = master 0, slice 1 = master 1
    input  logic [1:0]            M_AW_VALID,
    output logic [1:0]            M_AW_READY,
    input  logic [2*ADDR_W-1:0]   M_AW_ADDR,
    input  logic [1:0]            M_W_VALID,
    output logic [1:0]            M_W_READY,
    input  logic [2*DATA_W-1:0]   M_W_DATA,
    input  logic [2*DATA_W/8-1:0] M_W_STRB,
    output logic [1:0]            M_B_VALID,
    input  logic [1:0]            M_B_READY,
    output logic [3:0]            M_B_RESP,
    input  logic [1:0]            M_AR_VALID,
    output logic [1:0]            M_AR_READY,
    input  logic [2*ADDR_W-1:0]   M_AR_ADDR,
    output logic [1:0]            M_R_VALID,
    input  logic [1:0]            M_R_READY,
    output logic [2*DATA_W-1:0]   M_R_DATA,
    output logic [3:0]            M_R_RESP,
    // slave side
    output logic                  S_AW_VALID,
    input  logic                  S_AW_READY,
    output logic [ADDR_W-1:0]     S_AW_ADDR,
    output logic                  S_W_VALID,
    input  logic                  S_W_READY,
    output logic [DATA_W-1:0]     S_W_DATA,
    output logic [DATA_W/8-1:0]   S_W_STRB,
    input  logic                  S_B_VALID,
    output logic                  S_B_READY,
    input  logic [1:0]            S_B_RESP,
    output logic                  S_AR_VALID,
    input  logic                  S_AR_READY,
    output logic [ADDR_W-1:0]     S_AR_ADDR,
    input  logic                  S_R_VALID,
    output logic                  S_R_READY,
    input  logic [DATA_W-1:0]     S_R_DATA,
    input  logic [1:0]            S_R_RESP
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;
    logic   r_rr,      w_rr_nxt;
    logic   r_gnt,     w_gnt_nxt;
    logic   r_aw_done, w_aw_done_nxt;
    logic   r_w_done,  w_w_done_nxt;
    logic   r_ar_done, w_ar_done_nxt;

    logic [1:0]        w_req;
    logic              w_pref;
    logic              w_sel;
    logic [ADDR_W-1:0] w_aw_addr;
    logic [ADDR_W-1:0] w_ar_addr;
    logic [DATA_W-1:0] w_w_data;
    logic [STRB_W-1:0] w_w_strb;
    logic              w_aw_vld;
    logic              w_w_vld;
    logic              w_ar_vld;
    logic              w_b_rdy;
    logic              w_r_rdy;

    assign w_req = M_AW_VALID | M_AR_VALID;

`ifdef ARB_FIXED_PRIORITY_EN
    assign w_pref = 1'b0;
`else
    assign w_pref = r_rr;
`endif

    // The non-preferred master wins only when the preferred one is silent.
    assign w_sel = w_req[w_pref] ? w_pref : ~w_pref;

    assign w_aw_addr = r_gnt ? M_AW_ADDR[2*ADDR_W-1:ADDR_W] : M_AW_ADDR[ADDR_W-1:0];
    assign w_ar_addr = r_gnt ? M_AR_ADDR[2*ADDR_W-1:ADDR_W] : M_AR_ADDR[ADDR_W-1:0];
    assign w_w_data  = r_gnt ? M_W_DATA[2*DATA_W-1:DATA_W]  : M_W_DATA[DATA_W-1:0];
    assign w_w_strb  = r_gnt ? M_W_STRB[2*STRB_W-1:STRB_W]  : M_W_STRB[STRB_W-1:0];
    assign w_aw_vld  = M_AW_VALID[r_gnt];
    assign w_w_vld   = M_W_VALID[r_gnt];
    assign w_ar_vld  = M_AR_VALID[r_gnt];
    assign w_b_rdy   = M_B_READY[r_gnt];
    assign w_r_rdy   = M_R_READY[r_gnt];

    always_comb begin
        M_AW_READY    = '0;
        M_W_READY     = '0;
        M_B_VALID     = '0;
        M_B_RESP      = '0;
        M_AR_READY    = '0;
        M_R_VALID     = '0;
        M_R_DATA      = '0;
        M_R_RESP      = '0;
        S_AW_VALID    = 1'b0;
        S_AW_ADDR     = '0;
        S_W_VALID     = 1'b0;
        S_W_DATA      = '0;
        S_W_STRB      = '0;
        S_B_READY     = 1'b0;
        S_AR_VALID    = 1'b0;
        S_AR_ADDR     = '0;
        S_R_READY     = 1'b0;
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr;
        w_gnt_nxt     = r_gnt;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_ar_done_nxt = r_ar_done;

        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_gnt_nxt   = w_sel;
                    w_state_nxt = M_AW_VALID[w_sel] ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                S_AW_VALID        = w_aw_vld & ~r_aw_done;
                S_AW_ADDR         = w_aw_addr;
                M_AW_READY[r_gnt] = S_AW_READY & ~r_aw_done;
                S_W_VALID         = w_w_vld & ~r_w_done;
                S_W_DATA          = w_w_data;
                S_W_STRB          = w_w_strb;
                M_W_READY[r_gnt]  = S_W_READY & ~r_w_done;
                M_B_VALID[r_gnt]  = S_B_VALID;
                S_B_READY         = w_b_rdy;
                if (r_gnt) M_B_RESP[3:2] = S_B_RESP;
                else       M_B_RESP[1:0] = S_B_RESP;

                if (w_aw_vld & ~r_aw_done & S_AW_READY) w_aw_done_nxt = 1'b1;
                if (w_w_vld & ~r_w_done & S_W_READY)    w_w_done_nxt  = 1'b1;
                if (S_B_VALID & w_b_rdy) begin
                    w_state_nxt   = ST_IDLE;
                    w_rr_nxt      = ~r_gnt;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end
            end
            ST_READ: begin
                S_AR_VALID        = w_ar_vld & ~r_ar_done;
                S_AR_ADDR         = w_ar_addr;
                M_AR_READY[r_gnt] = S_AR_READY & ~r_ar_done;
                M_R_VALID[r_gnt]  = S_R_VALID;
                S_R_READY         = w_r_rdy;
                if (r_gnt) begin
                    M_R_DATA[2*DATA_W-1:DATA_W] = S_R_DATA;
                    M_R_RESP[3:2]               = S_R_RESP;
                end else begin
                    M_R_DATA[DATA_W-1:0]        = S_R_DATA;
                    M_R_RESP[1:0]               = S_R_RESP;
                end

                if (w_ar_vld & ~r_ar_done & S_AR_READY) w_ar_done_nxt = 1'b1;
                if (S_R_VALID & w_r_rdy) begin
                    w_state_nxt   = ST_IDLE;
                    w_rr_nxt      = ~r_gnt;
                    w_ar_done_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= ST_IDLE;
            r_rr      <= 1'b0;
            r_gnt     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_ar_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr      <= w_rr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            r_ar_done <= w_ar_done_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_arbiter.sv
// ============================================================================
// Module      : tb_axi4_lite_arbiter
// Description : Scoreboard bench for axi4_lite_arbiter with a reactive slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi4_lite_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;

    logic [1:0]      M_AW_VALID, M_AW_READY, M_W_VALID, M_W_READY, M_B_VALID, M_B_READY;
    logic [1:0]      M_AR_VALID, M_AR_READY, M_R_VALID, M_R_READY;
    logic [2*AW-1:0] M_AW_ADDR, M_AR_ADDR;
    logic [2*DW-1:0] M_W_DATA, M_R_DATA;
    logic [2*SW-1:0] M_W_STRB;
    logic [3:0]      M_B_RESP, M_R_RESP;
    logic            S_AW_VALID, S_AW_READY, S_W_VALID, S_W_READY, S_B_VALID, S_B_READY;
    logic            S_AR_VALID, S_AR_READY, S_R_VALID, S_R_READY;
    logic [AW-1:0]   S_AW_ADDR, S_AR_ADDR;
    logic [DW-1:0]   S_W_DATA, S_R_DATA;
    logic [SW-1:0]   S_W_STRB;
    logic [1:0]      S_B_RESP, S_R_RESP;

    always #5 ACLK = ~ACLK;

    axi4_lite_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M_AW_VALID(M_AW_VALID), .M_AW_READY(M_AW_READY), .M_AW_ADDR(M_AW_ADDR),
        .M_W_VALID(M_W_VALID), .M_W_READY(M_W_READY), .M_W_DATA(M_W_DATA), .M_W_STRB(M_W_STRB),
        .M_B_VALID(M_B_VALID), .M_B_READY(M_B_READY), .M_B_RESP(M_B_RESP),
        .M_AR_VALID(M_AR_VALID), .M_AR_READY(M_AR_READY), .M_AR_ADDR(M_AR_ADDR),
        .M_R_VALID(M_R_VALID), .M_R_READY(M_R_READY), .M_R_DATA(M_R_DATA), .M_R_RESP(M_R_RESP),
        .S_AW_VALID(S_AW_VALID), .S_AW_READY(S_AW_READY), .S_AW_ADDR(S_AW_ADDR),
        .S_W_VALID(S_W_VALID), .S_W_READY(S_W_READY), .S_W_DATA(S_W_DATA), .S_W_STRB(S_W_STRB),
        .S_B_VALID(S_B_VALID), .S_B_READY(S_B_READY), .S_B_RESP(S_B_RESP),
        .S_AR_VALID(S_AR_VALID), .S_AR_READY(S_AR_READY), .S_AR_ADDR(S_AR_ADDR),
        .S_R_VALID(S_R_VALID), .S_R_READY(S_R_READY), .S_R_DATA(S_R_DATA), .S_R_RESP(S_R_RESP)
    );

    logic w_any_out;
    assign w_any_out = |{M_AW_READY, M_W_READY, M_B_VALID, M_B_RESP, M_AR_READY, M_R_VALID,
                         M_R_DATA, M_R_RESP, S_AW_VALID, S_AW_ADDR, S_W_VALID, S_W_DATA,
                         S_W_STRB, S_B_READY, S_AR_VALID, S_AR_ADDR, S_R_READY};

    typedef struct {
        bit          wr;
        int          m;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          gap2;
    } slv_t;

    typedef struct {
        bit          wr;
        int          m;
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    slv_t exp_slv[$];
    rsp_t exp_rsp[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_rsp_cyc = 0;
    int slv_aw_delay = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name, input string what);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic void push_w(int m, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        slv_t e;
        e = '{wr: 1'b1, m: m, addr: a, data: d, strb: s, gap2: 1'b0};
        exp_slv.push_back(e);
    endfunction

    function automatic void push_r(int m, logic [31:0] a, bit gap2);
        slv_t e;
        e = '{wr: 1'b0, m: m, addr: a, data: 32'h0, strb: 4'h0, gap2: gap2};
        exp_slv.push_back(e);
    endfunction

    function automatic void push_rsp(bit wr, int m, logic [31:0] d, logic [1:0] r);
        rsp_t e;
        e = '{wr: wr, m: m, data: d, resp: r};
        exp_rsp.push_back(e);
    endfunction

    // Reactive slave: always-ready W/AR, optional AW stall, B/R one cycle later.
    // Read data = 0xA0000000 | addr; RESP = addr[3:2] for both B and R.
    logic        s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs, s_got_aw, s_got_w;
    logic [31:0] s_waddr, s_raddr;
    int          s_aw_cnt;

    initial begin
        S_AW_READY = 1'b1; S_W_READY = 1'b1; S_AR_READY = 1'b1;
        S_B_VALID = 1'b0; S_B_RESP = '0; S_R_VALID = 1'b0; S_R_DATA = '0; S_R_RESP = '0;
        s_got_aw = 1'b0; s_got_w = 1'b0; s_aw_cnt = 0; s_waddr = '0; s_raddr = '0;
        forever begin
            @(negedge ACLK);
            s_aw_hs = S_AW_VALID & S_AW_READY;
            s_w_hs  = S_W_VALID & S_W_READY;
            s_b_hs  = S_B_VALID & S_B_READY;
            s_ar_hs = S_AR_VALID & S_AR_READY;
            s_r_hs  = S_R_VALID & S_R_READY;
            if (s_aw_hs) s_waddr = S_AW_ADDR;
            if (s_ar_hs) s_raddr = S_AR_ADDR;
            if (S_AW_VALID & !S_AW_READY) s_aw_cnt++;
            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                S_B_VALID = 1'b0; S_R_VALID = 1'b0;
                s_got_aw = 1'b0; s_got_w = 1'b0; s_aw_cnt = 0;
            end else begin
                if (s_aw_hs) begin s_got_aw = 1'b1; s_aw_cnt = 0; end
                if (s_w_hs) s_got_w = 1'b1;
                if (s_b_hs) S_B_VALID = 1'b0;
                if (s_got_aw && s_got_w && !S_B_VALID) begin
                    S_B_VALID = 1'b1;
                    S_B_RESP  = s_waddr[3:2];
                    s_got_aw  = 1'b0;
                    s_got_w   = 1'b0;
                end
                if (s_r_hs) S_R_VALID = 1'b0;
                if (s_ar_hs) begin
                    S_R_VALID = 1'b1;
                    S_R_DATA  = 32'hA000_0000 | s_raddr;
                    S_R_RESP  = s_raddr[3:2];
                end
            end
            S_AW_READY = (s_aw_cnt >= slv_aw_delay);
        end
    end

    // Monitor: pops the scoreboard on every slave-side and master-side handshake.
    bit   mon_aw_seen = 1'b0;
    bit   mon_w_seen  = 1'b0;
    slv_t mon_s;
    rsp_t mon_r;
    logic act0, act1;

    initial begin
        forever begin
            @(negedge ACLK);
            cyc++;
            if (ARESETn) begin
                act0 = M_AW_READY[0] | M_W_READY[0] | M_B_VALID[0] | M_AR_READY[0] | M_R_VALID[0];
                act1 = M_AW_READY[1] | M_W_READY[1] | M_B_VALID[1] | M_AR_READY[1] | M_R_VALID[1];
                if (act0 & act1) bad("exclusive", "both masters active");

                if (S_AR_VALID & S_AR_READY) begin
                    if (exp_slv.size() == 0 || exp_slv[0].wr) bad("ar_order", "unexpected read");
                    else begin
                        mon_s = exp_slv.pop_front();
                        chk("ar_addr", S_AR_ADDR, mon_s.addr);
                        chk("ar_owner", M_AR_READY, 64'(1 << mon_s.m));
                        if (mon_s.gap2) chk("ar_gap", 64'(cyc - last_rsp_cyc), 64'd2);
                    end
                end
                if (S_AW_VALID & S_AW_READY) begin
                    if (exp_slv.size() == 0 || !exp_slv[0].wr || mon_aw_seen)
                        bad("aw_order", "unexpected write address");
                    else begin
                        chk("aw_addr", S_AW_ADDR, exp_slv[0].addr);
                        chk("aw_owner", M_AW_READY, 64'(1 << exp_slv[0].m));
                        mon_aw_seen = 1'b1;
                    end
                end
                if (S_W_VALID & S_W_READY) begin
                    if (exp_slv.size() == 0 || !exp_slv[0].wr || mon_w_seen)
                        bad("w_order", "unexpected write data");
                    else begin
                        chk("w_data", S_W_DATA, exp_slv[0].data);
                        chk("w_strb", S_W_STRB, exp_slv[0].strb);
                        chk("w_owner", M_W_READY, 64'(1 << exp_slv[0].m));
                        mon_w_seen = 1'b1;
                    end
                end
                if (mon_aw_seen && mon_w_seen) begin
                    void'(exp_slv.pop_front());
                    mon_aw_seen = 1'b0;
                    mon_w_seen  = 1'b0;
                end

                if (|(M_B_VALID & M_B_READY)) begin
                    last_rsp_cyc = cyc;
                    if (exp_rsp.size() == 0 || !exp_rsp[0].wr) bad("b_order", "unexpected B");
                    else begin
                        mon_r = exp_rsp.pop_front();
                        chk("b_owner", M_B_VALID, 64'(1 << mon_r.m));
                        chk("b_resp", M_B_RESP, 64'(mon_r.resp) << (2 * mon_r.m));
                    end
                end
                if (|(M_R_VALID & M_R_READY)) begin
                    last_rsp_cyc = cyc;
                    if (exp_rsp.size() == 0 || exp_rsp[0].wr) bad("r_order", "unexpected R");
                    else begin
                        mon_r = exp_rsp.pop_front();
                        chk("r_owner", M_R_VALID, 64'(1 << mon_r.m));
                        chk("r_data", M_R_DATA, 64'(mon_r.data) << (32 * mon_r.m));
                        chk("r_resp", M_R_RESP, 64'(mon_r.resp) << (2 * mon_r.m));
                    end
                end
            end
        end
    end

    task automatic m_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead);
        bit a_done = 1'b0, d_done = 1'b0, ah, wh, got = 1'b0;
        M_W_DATA[m*DW +: DW] = data;
        M_W_STRB[m*SW +: SW] = strb;
        M_W_VALID[m] = 1'b1;
        repeat (w_lead) begin @(posedge ACLK); #1; end
        M_AW_ADDR[m*AW +: AW] = addr;
        M_AW_VALID[m] = 1'b1;
        for (int k = 0; k < 50 && !(a_done && d_done); k++) begin
            @(negedge ACLK);
            ah = M_AW_VALID[m] & M_AW_READY[m];
            wh = M_W_VALID[m] & M_W_READY[m];
            @(posedge ACLK); #1;
            if (ah) begin M_AW_VALID[m] = 1'b0; a_done = 1'b1; end
            if (wh) begin M_W_VALID[m] = 1'b0; d_done = 1'b1; end
        end
        if (!(a_done && d_done)) begin
            bad("wr_handshake", "timeout");
            M_AW_VALID[m] = 1'b0;
            M_W_VALID[m]  = 1'b0;
            return;
        end
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge ACLK);
            got = M_B_VALID[m] & M_B_READY[m];
            @(posedge ACLK); #1;
        end
        if (!got) bad("b_wait", "timeout");
    endtask

    task automatic m_read(input int m, input logic [31:0] addr);
        bit got = 1'b0;
        M_AR_ADDR[m*AW +: AW] = addr;
        M_AR_VALID[m] = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge ACLK);
            got = M_AR_VALID[m] & M_AR_READY[m];
            @(posedge ACLK); #1;
        end
        M_AR_VALID[m] = 1'b0;
        if (!got) begin bad("ar_wait", "timeout"); return; end
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge ACLK);
            got = M_R_VALID[m] & M_R_READY[m];
            @(posedge ACLK); #1;
        end
        if (!got) bad("r_wait", "timeout");
    endtask

    initial begin
        bit got;
        M_AW_VALID = '0; M_AW_ADDR = '0; M_W_VALID = '0; M_W_DATA = '0; M_W_STRB = '0;
        M_AR_VALID = '0; M_AR_ADDR = '0; M_B_READY = 2'b11; M_R_READY = 2'b11;

        // Reset: every output low, and still low once released into IDLE.
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("reset_outs", 64'(w_any_out), 64'd0);
        #1 ARESETn = 1'b1;
        @(negedge ACLK);
        chk("idle_outs", 64'(w_any_out), 64'd0);
        @(posedge ACLK); #1;

        // Contention from reset: M0 (0x20) first, M1 (0x40) two cycles after R handshake.
        push_r(0, 32'h20, 1'b0); push_r(1, 32'h40, 1'b1);
        push_rsp(1'b0, 0, 32'hA000_0020, 2'd0); push_rsp(1'b0, 1, 32'hA000_0040, 2'd0);
        fork
            m_read(0, 32'h20);
            m_read(1, 32'h40);
        join

        // Single write from M0, one-cycle arbitration latency.
        push_w(0, 32'h10, 32'hDEAD_BEEF, 4'hF); push_rsp(1'b1, 0, 32'h0, 2'd0);
        fork
            m_write(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
            begin
                @(negedge ACLK);
                chk("lat_idle_awvalid", 64'(S_AW_VALID), 64'd0);
                chk("lat_idle_awaddr", 64'(S_AW_ADDR), 64'd0);
                @(negedge ACLK);
                chk("lat_awvalid", 64'(S_AW_VALID), 64'd1);
                chk("lat_awaddr", 64'(S_AW_ADDR), 64'h10);
                chk("lat_wdata", 64'(S_W_DATA), 64'hDEAD_BEEF);
            end
        join

        // M1 AW (0x8) and AR (0xC) together: write first.
        push_w(1, 32'h8, 32'h1234_5678, 4'h3); push_r(1, 32'hC, 1'b0);
        push_rsp(1'b1, 1, 32'h0, 2'd2); push_rsp(1'b0, 1, 32'hA000_000C, 2'd3);
        fork
            m_write(1, 32'h8, 32'h1234_5678, 4'h3, 0);
            m_read(1, 32'hC);
        join

        // M0 back-to-back reads while M1 waits.
`ifdef ARB_FIXED_PRIORITY_EN
        push_r(0, 32'h50, 1'b0); push_r(0, 32'h54, 1'b0); push_r(1, 32'h60, 1'b0);
        push_rsp(1'b0, 0, 32'hA000_0050, 2'd0); push_rsp(1'b0, 0, 32'hA000_0054, 2'd1);
        push_rsp(1'b0, 1, 32'hA000_0060, 2'd0);
`else
        push_r(0, 32'h50, 1'b0); push_r(1, 32'h60, 1'b0); push_r(0, 32'h54, 1'b0);
        push_rsp(1'b0, 0, 32'hA000_0050, 2'd0); push_rsp(1'b0, 1, 32'hA000_0060, 2'd0);
        push_rsp(1'b0, 0, 32'hA000_0054, 2'd1);
`endif
        fork
            begin m_read(0, 32'h50); m_read(0, 32'h54); end
            m_read(1, 32'h60);
        join

        // W leads AW by 3 cycles and the slave stalls AW, so W completes alone.
        slv_aw_delay = 2;
        push_w(0, 32'h44, 32'hCAFE_F00D, 4'hC); push_rsp(1'b1, 0, 32'h0, 2'd1);
        m_write(0, 32'h44, 32'hCAFE_F00D, 4'hC, 3);
        slv_aw_delay = 0;

        // Reset in READ with R pending; afterwards rr must be back at master 0.
        M_R_READY[0] = 1'b0;
        push_r(0, 32'h30, 1'b0);
        M_AR_ADDR[AW-1:0] = 32'h30;
        M_AR_VALID[0] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge ACLK);
            got = M_AR_VALID[0] & M_AR_READY[0];
            @(posedge ACLK); #1;
        end
        M_AR_VALID[0] = 1'b0;
        if (!got) bad("rst_ar_wait", "timeout");
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge ACLK);
            got = S_R_VALID;
        end
        if (!got) bad("rst_r_pending", "timeout");
        else chk("rst_r_pending", 64'(M_R_VALID), 64'd1);
        #2 ARESETn = 1'b0;
        #1 chk("rst_mid_outs", 64'(w_any_out), 64'd0);
        M_R_READY[0] = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        #1 ARESETn = 1'b1;
        @(posedge ACLK); #1;

        push_r(0, 32'h70, 1'b0); push_r(1, 32'h74, 1'b0);
        push_rsp(1'b0, 0, 32'hA000_0070, 2'd0); push_rsp(1'b0, 1, 32'hA000_0074, 2'd1);
        fork
            m_read(0, 32'h70);
            m_read(1, 32'h74);
        join

        for (int k = 0; k < 20 && (exp_slv.size() != 0 || exp_rsp.size() != 0); k++)
            @(negedge ACLK);
        chk("sb_slave_empty", 64'(exp_slv.size()), 64'd0);
        chk("sb_resp_empty", 64'(exp_rsp.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish by 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
